// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage driving a single-outstanding word bus with byte strobes,
// returning extended load data or a store ack, with alignment checks and a bus timeout.
package mem_access_pkg;
    typedef enum logic [2:0] {
        MEM_NONE, MEM_READ_BYTE, MEM_READ_HALF, MEM_READ_WORD,
        MEM_STORE_BYTE, MEM_STORE_HALF, MEM_STORE_WORD
    } mem_ctrl_t;
endpackage

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  mem_ctrl_t   mem_ctrl,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    mem_ctrl_t   op;
    logic [1:0]  lane;
    logic        uns;
    logic [15:0] ctr;
    logic        is_store, is_half, is_word, misaligned;
    logic [3:0]  strb;
    logic [31:0] lane_wdata, load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_store   = mem_ctrl inside {MEM_STORE_BYTE, MEM_STORE_HALF, MEM_STORE_WORD};
        is_half    = mem_ctrl inside {MEM_READ_HALF, MEM_STORE_HALF};
        is_word    = mem_ctrl inside {MEM_READ_WORD, MEM_STORE_WORD};
        misaligned = (is_half && addr[0]) || (is_word && addr[1:0] != 2'b00);
        strb       = !is_store ? 4'b0000 : is_word ? 4'hF : is_half ? (addr[1] ? 4'b1100 : 4'b0011)
                   : 4'b0001 << addr[1:0];
        lane_wdata = is_word ? wdata : is_half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        ld_byte    = bus_rdata[{lane, 3'b000} +: 8];
        ld_half    = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_data  = op == MEM_READ_WORD ? bus_rdata
                   : op == MEM_READ_HALF ? {{16{~uns & ld_half[15]}}, ld_half}
                   : op == MEM_READ_BYTE ? {{24{~uns & ld_byte[7]}}, ld_byte} : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op            <= MEM_NONE;
            lane          <= 2'b00;
            uns           <= 1'b0;
            ctr           <= 16'd0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_err      <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_addr      <= 32'd0;
            bus_we        <= 1'b0;
            bus_wstrb     <= 4'b0000;
            bus_wdata     <= 32'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op        <= mem_ctrl;
                    lane      <= addr[1:0];
                    uns       <= mem_unsigned;
                    req_ready <= 1'b0;
                    if (mem_ctrl == MEM_NONE || misaligned) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_err   <= misaligned;
                    end else begin
                        state         <= REQ;
                        bus_req_valid <= 1'b1;
                        bus_addr      <= {addr[31:2], 2'b00};
                        bus_we        <= is_store;
                        bus_wstrb     <= strb;
                        bus_wdata     <= is_store ? lane_wdata : 32'd0;
                    end
                end
                REQ: if (bus_req_ready) begin
                    state         <= WAIT;
                    bus_req_valid <= 1'b0;
                    ctr           <= 16'd0;
                end
                WAIT: begin
                    // A response on the final counted cycle still beats the timeout
                    if (bus_rsp_valid) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        resp_err   <= 1'b0;
                    end else if (ctr == 16'(TIMEOUT_CYCLES - 1)) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b1;
                    end else begin
                        ctr <= ctr + 16'd1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
